// File: rtl/serdes_pkg.sv
// Shared types and defaults for the framed serial link (receiver and future transmitter).
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package serdes_pkg;

  // Frame receiver alignment states.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Link defaults shared by both ends of the framed link.
  localparam int                     DEF_WIDTH       = 32;
  localparam logic [DEF_WIDTH-1:0]   DEF_SYNC_WORD   = 32'hA5C3_0F96;
  localparam int                     DEF_FRAME_WORDS = 4;
  localparam int                     DEF_LOCK_COUNT  = 2;
  localparam int                     DEF_LOSS_COUNT  = 3;

  // Width of an index over n positions (0..n-1), never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold the value n itself (0..n).
  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/des_shift_cmp.sv
// Serial-in shift register with a combinational sync-word comparator on the next value.
// Latency: match/sr_next are combinational on the current bit; the register updates on enabled edges.
// Backpressure: none; enable low freezes the register.
module des_shift_cmp
  import serdes_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] SYNC_WORD = DEF_SYNC_WORD
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             din,
  output logic [WIDTH-1:0] sr_next,
  output logic             match
);

  logic [WIDTH-1:0] sr;

  // Next register value: MSB-first, so the newest bit lands in the LSB.
  always_comb begin
    sr_next = {sr[WIDTH-2:0], din};
    match   = (sr_next == SYNC_WORD);
  end

  // Shift one bit per enabled cycle; reset clears all history.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (enable) begin
      sr <= sr_next;
    end
  end

endmodule

// File: rtl/des_frame_sync.sv
// Framed serial receiver: hunts for a sync word, confirms alignment, delivers data words.
// Latency: a data word is presented one clock after the cycle carrying its LSB.
// Backpressure: none; enable low holds all state and suppresses pulses.
module des_frame_sync
  import serdes_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] SYNC_WORD   = DEF_SYNC_WORD,
  parameter int               FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int               LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int               LOSS_COUNT  = DEF_LOSS_COUNT
) (
  input  logic                                clock,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic                                din,
  output logic [WIDTH-1:0]                    dout,
  output logic                                dout_valid,
  output logic [idx_width(FRAME_WORDS)-1:0]   word_idx,
  output logic                                frame_start,
  output logic                                locked,
  output logic                                sync_err
);

  localparam int IDXW   = idx_width(FRAME_WORDS);
  localparam int BITW   = idx_width(WIDTH);
  localparam int CNTW   = cnt_width(FRAME_WORDS);
  localparam int MATCHW = cnt_width(LOCK_COUNT);
  localparam int MISSW  = cnt_width(LOSS_COUNT);

  localparam logic [BITW-1:0]   BIT_LAST  = BITW'(WIDTH - 1);
  localparam logic [CNTW-1:0]   SYNC_SLOT = CNTW'(FRAME_WORDS);
  localparam logic [MATCHW-1:0] MATCH_ONE = MATCHW'(1);
  localparam logic [MATCHW-1:0] LOCK_MAX  = MATCHW'(LOCK_COUNT);
  localparam logic [MISSW-1:0]  LOSS_MAX  = MISSW'(LOSS_COUNT);

  logic [WIDTH-1:0]  sr_next;
  logic              match;
  state_t            state;
  logic [BITW-1:0]   bit_cnt;
  logic [CNTW-1:0]   word_cnt;
  logic [MATCHW-1:0] match_cnt;
  logic [MISSW-1:0]  miss_cnt;
  logic              slot_done;
  logic              sync_slot;

  des_shift_cmp #(
    .WIDTH     (WIDTH),
    .SYNC_WORD (SYNC_WORD)
  ) u_shift_cmp (
    .clock   (clock),
    .rst_n   (rst_n),
    .enable  (enable),
    .din     (din),
    .sr_next (sr_next),
    .match   (match)
  );

  // Slot boundary decode: last bit of a slot, and whether that slot is the sync position.
  always_comb begin
    slot_done = (bit_cnt == BIT_LAST);
    sync_slot = (word_cnt == SYNC_SLOT);
  end

  // Alignment FSM, slot counters and registered outputs; pulse outputs default low every cycle.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state       <= HUNT;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      word_idx    <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      if (enable) begin
        // Slot counting runs whenever alignment is assumed; both counters wrap back
        // to zero at the end of the sync slot, so any exit to HUNT leaves them clean.
        if (state != HUNT) begin
          bit_cnt <= slot_done ? '0 : bit_cnt + 1'b1;
          if (slot_done) begin
            word_cnt <= sync_slot ? '0 : word_cnt + 1'b1;
          end
        end
        case (state)
          HUNT: begin
            // Sliding search: every enabled bit is a candidate sync end.
            if (match) begin
              bit_cnt   <= '0;
              word_cnt  <= '0;
              match_cnt <= MATCH_ONE;
              if (LOCK_COUNT == 1) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end else begin
                state <= VERIFY;
              end
            end
          end
          VERIFY: begin
            // Data slots are skipped; only the sync slot votes on the candidate alignment.
            if (slot_done && sync_slot) begin
              if (match) begin
                match_cnt <= match_cnt + 1'b1;
                if (match_cnt + 1'b1 == LOCK_MAX) begin
                  state    <= LOCKED;
                  locked   <= 1'b1;
                  miss_cnt <= '0;
                end
              end else begin
                // Candidate was a false hit; search resumes with the next bit.
                state     <= HUNT;
                match_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            if (slot_done) begin
              if (!sync_slot) begin
                // Data slot: sync-looking data is deliberately not inspected here.
                dout        <= sr_next;
                dout_valid  <= 1'b1;
                word_idx    <= IDXW'(word_cnt);
                frame_start <= (word_cnt == '0);
              end else if (match) begin
                miss_cnt <= '0;
              end else begin
                // Flywheel: tolerate isolated sync misses, drop lock on a run of them.
                sync_err <= 1'b1;
                if (miss_cnt + 1'b1 == LOSS_MAX) begin
                  state     <= HUNT;
                  locked    <= 1'b0;
                  miss_cnt  <= '0;
                  match_cnt <= '0;
                end else begin
                  miss_cnt <= miss_cnt + 1'b1;
                end
              end
            end
          end
          default: begin
            state <= HUNT;
          end
        endcase
      end
    end
  end

endmodule
